// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared types and constants for the irrigation sequencer
package irrigation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_WATER = 2'd2,
        ST_CLOSE = 2'd3
    } state_t;

    localparam int AREA_A = 0;
    localparam int AREA_B = 1;

    localparam int DEFAULT_SETTLE_CYCLES = 2;
    localparam int DEFAULT_WATER_CYCLES  = 8;

    function automatic int timer_width(input int settle, input int water);
        int longest;
        int bits;
        longest = (settle > water) ? settle : water;
        bits    = $clog2(longest);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/irr_timer.sv
// rtl/irr_timer.sv - loadable down-counter that saturates at zero
module irr_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/irrigation_sequencer.sv
// rtl/irrigation_sequencer.sv - two-area valve/pump watering sequencer
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int WATER_CYCLES  = DEFAULT_WATER_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] valve,
    output logic       pump,
    output logic       busy,
    output logic       done
);

    localparam int CW = timer_width(SETTLE_CYCLES, WATER_CYCLES);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] WATER_LOAD  = CW'(WATER_CYCLES - 1);

    state_t          state;
    logic            sel;
    logic            last;
    logic            done_q;
    logic            pick;
    logic            req_sel;
    logic            load;
    logic [CW-1:0]   load_value;
    logic            zero;

    // On a tie, serve whichever area was not served most recently.
    assign pick    = req[1] & (~req[0] | (last == 1'(AREA_A)));
    assign req_sel = req[sel];

    always_comb begin
        load       = 1'b0;
        load_value = SETTLE_LOAD;
        case (state)
            ST_IDLE:  load = |req;
            ST_OPEN: begin
                load       = zero;
                load_value = WATER_LOAD;
            end
            ST_WATER: load = zero | ~req_sel;
            ST_CLOSE: load = 1'b0;
            default:  load = 1'b0;
        endcase
    end

    irr_timer #(.WIDTH(CW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_value (load_value),
        .zero       (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sel    <= 1'(AREA_A);
            last   <= 1'(AREA_B);
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        sel   <= pick;
                        state <= ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (zero) state <= ST_WATER;
                end
                ST_WATER: begin
                    // Area reporting adequate ends watering early.
                    if (zero || !req_sel) state <= ST_CLOSE;
                end
                ST_CLOSE: begin
                    if (zero) begin
                        state  <= ST_IDLE;
                        last   <= sel;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state != ST_IDLE);
    assign valve = busy ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign pump  = (state == ST_WATER);
    assign done  = done_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb/tb_irrigation_sequencer.sv - directed table-driven bench for irrigation_sequencer
module tb_irrigation_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] valve;
    logic       pump;
    logic       busy;
    logic       done;

    int checks;
    int failures;

    typedef struct {
        logic [1:0] req;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    irrigation_sequencer #(
        .SETTLE_CYCLES (2),
        .WATER_CYCLES  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .valve (valve),
        .pump  (pump),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {valve,pump,busy,done}=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] r, input logic [1:0] v, input logic p,
                       input logic b, input logic d, input int n);
        vec_t e;
        e.req = r;
        e.exp = {v, p, b, d};
        for (int k = 0; k < n; k++) tbl.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 2'b00;

        // Both dry from reset: A first, one IDLE cycle, then B.
        add(2'b11, 2'b01, 0, 1, 0, 2);
        add(2'b11, 2'b01, 1, 1, 0, 8);
        add(2'b11, 2'b01, 0, 1, 0, 2);
        add(2'b11, 2'b00, 0, 0, 1, 1);
        add(2'b11, 2'b10, 0, 1, 0, 2);
        add(2'b11, 2'b10, 1, 1, 0, 8);
        add(2'b11, 2'b10, 0, 1, 0, 2);
        add(2'b00, 2'b00, 0, 0, 1, 1);
        // Quiet period.
        add(2'b00, 2'b00, 0, 0, 0, 20);
        // Single area A, full length.
        add(2'b01, 2'b01, 0, 1, 0, 2);
        add(2'b01, 2'b01, 1, 1, 0, 8);
        add(2'b01, 2'b01, 0, 1, 0, 2);
        add(2'b00, 2'b00, 0, 0, 1, 1);
        add(2'b00, 2'b00, 0, 0, 0, 1);
        // Early stop after 3 water cycles.
        add(2'b01, 2'b01, 0, 1, 0, 2);
        add(2'b01, 2'b01, 1, 1, 0, 3);
        add(2'b00, 2'b01, 0, 1, 0, 2);
        add(2'b00, 2'b00, 0, 0, 1, 1);
        add(2'b00, 2'b00, 0, 0, 0, 1);
        // Other-area request ignored until IDLE; then B stops after 1 water cycle.
        add(2'b01, 2'b01, 0, 1, 0, 1);
        add(2'b10, 2'b01, 0, 1, 0, 1);
        add(2'b11, 2'b01, 1, 1, 0, 8);
        add(2'b10, 2'b01, 0, 1, 0, 2);
        add(2'b10, 2'b00, 0, 0, 1, 1);
        add(2'b10, 2'b10, 0, 1, 0, 1);
        add(2'b00, 2'b10, 0, 1, 0, 1);
        add(2'b00, 2'b10, 1, 1, 0, 1);
        add(2'b00, 2'b10, 0, 1, 0, 2);
        add(2'b00, 2'b00, 0, 0, 1, 1);
        add(2'b00, 2'b00, 0, 0, 0, 1);

        #1;
        check("reset_hold", {valve, pump, busy, done}, 5'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", {valve, pump, busy, done}, 5'b0);

        foreach (tbl[i]) begin
            @(negedge clk);
            req = tbl[i].req;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {valve, pump, busy, done}, tbl[i].exp);
        end

        // Pointer currently B-served; reset must restore it so a tie serves A.
        @(negedge clk);
        req = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("pre_a_open", {valve, pump, busy, done}, {2'b01, 1'b0, 1'b1, 1'b0});
        do_reset();
        req = 2'b11;
        repeat (6) @(posedge clk);
        #1;
        check("water4", {valve, pump, busy, done}, {2'b01, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", {valve, pump, busy, done}, 5'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d", k), {valve, pump, busy, done}, 5'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ptr_after_reset", {valve, pump, busy, done}, {2'b01, 1'b0, 1'b1, 1'b0});

        // Random stimulus against the output invariants.
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            req = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            checks++;
            if ((pump && valve == 2'b00) || valve == 2'b11 || (done && busy)) begin
                failures++;
                $display("FAIL invariant cycle %0d: valve=%b pump=%b busy=%b done=%b",
                         k, valve, pump, busy, done);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles a valve is held open with the pump off, before and after watering; must be >= 1.
REQ-002 Parameter WATER_CYCLES, default 8: maximum cycles the pump runs per watering; must be >= 1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  2  watering demand from the upstream irrigation control: bit0 = area A dry, bit1 = area B dry; 00 = both adequate.
REQ-006 valve  output  2  valve drive, one-hot or zero: bit0 = area A, bit1 = area B.
REQ-007 pump  output  1  pump drive; 1 = running.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking completion of a watering sequence.

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, OPEN, WATER and CLOSE.
REQ-011 In IDLE with req != 00 at a clock edge, the block SHALL latch the served area sel and enter OPEN on that edge.
REQ-012 Arbitration SHALL work as follows:
- req = 01 serves A.
- req = 10 serves B.
- req = 11 serves the area not served last.
- The last-served pointer resets to B, so A wins the first tie.
REQ-013 OPEN SHALL last exactly SETTLE_CYCLES cycles, then transition to WATER.
REQ-014 WATER SHALL last WATER_CYCLES cycles, then transition to CLOSE.
REQ-015 In WATER, if req[sel] samples 0 at an edge, the FSM SHALL enter CLOSE on that edge (early stop; the area is adequate).
REQ-016 CLOSE SHALL last exactly SETTLE_CYCLES cycles, then transition to IDLE; the last-served pointer SHALL update to sel on that transition.
REQ-017 Output decode SHALL be Moore from registered state, with no combinational path from req to any output:
- valve = one-hot(sel) in OPEN, WATER and CLOSE; 00 in IDLE.
- pump = 1 only in WATER.
- busy = (state != IDLE).
REQ-018 pump SHALL never be 1 while valve is 00, and valve SHALL never have both bits set.
REQ-019 done SHALL be 1 for exactly the first IDLE cycle following CLOSE, and 0 otherwise.
REQ-020 Every pass through CLOSE SHALL be followed by at least one IDLE cycle (valve 00) before any new OPEN.
REQ-021 Changes on req outside IDLE SHALL be ignored, except the req[sel] drop in WATER (REQ-015); a request for the other area waits in IDLE.
REQ-022 State durations SHALL be timed by one down-counter:
- The counter is sized to $clog2(max(SETTLE_CYCLES, WATER_CYCLES)) bits, minimum 1 bit.
- It loads N-1 on state entry.
- The state exits when the counter is 0 at a clock edge.
- The counter never wraps.

Reset
REQ-023 Asserting rst_n low SHALL immediately, and asynchronously, force all of the following: state = IDLE, valve = 00, pump = 0, busy = 0, done = 0, counter = 0, last-served = B.
REQ-024 A reset asserted mid-sequence, including during WATER, SHALL abort that sequence with no done pulse.
REQ-025 After rst_n deasserts, the first edge with req != 00 SHALL start a new sequence.

Structure
REQ-026 A shared package irrigation_pkg SHALL hold:
- the state enum type;
- area index constants AREA_A = 0 and AREA_B = 1;
- default values for SETTLE_CYCLES and WATER_CYCLES.
REQ-027 The down-counter SHALL be a sub-module irr_timer (inputs: load, load value; output: zero flag), instantiated once.
REQ-028 All FSM, counter and pointer flops SHALL use the asynchronous active-low reset.

Verification (SETTLE_CYCLES = 2, WATER_CYCLES = 8)
REQ-029 Single area: req = 01 held from the IDLE state leads to the following sequence (total busy = 12 cycles):
- valve = 01 with pump = 0 for 2 cycles;
- valve = 01 with pump = 1 for 8 cycles;
- valve = 01 with pump = 0 for 2 cycles;
- then valve = 00 with a done pulse lasting 1 cycle.
REQ-030 Both dry: req = 11 held from reset leads to a full A sequence, then exactly 1 IDLE cycle, then a full B sequence, with 2 done pulses in total.
REQ-031 Early stop: req = 01; drop req to 00 after 3 WATER cycles, which leads to CLOSE on that edge, with pump = 1 for exactly 3 cycles, then 2 CLOSE cycles and done.
REQ-032 Reset mid-water: assert rst_n = 0 during the 4th WATER cycle, which immediately forces valve = 00, pump = 0 and busy = 0, with no done pulse; the pointer returns to B, so a subsequent req = 11 serves A first.
REQ-033 Idle and invariants: with req = 00 for 20 cycles, valve, pump and done all stay 0; a random-req run of 1000 cycles never shows pump = 1 with valve = 00, nor valve = 11.
